// File: rtl/ixc_probe_pkg.sv
// Shared record layout and default sizing for the probe capture path.
package ixc_probe_pkg;
    localparam int PROBE_WIDTH = 7;
    localparam int PROBE_DEPTH = 8;
    localparam int PROBE_TS_W  = 16;
    localparam int REC_W       = PROBE_TS_W + PROBE_WIDTH;
    localparam int TS_LSB      = PROBE_WIDTH;
    localparam int DROP_CNT_W  = 8;

    typedef struct packed {
        logic [PROBE_TS_W-1:0]  ts;
        logic [PROBE_WIDTH-1:0] value;
    } probe_rec_t;
endpackage

// File: rtl/ixc_probe_fifo.sv
// Synchronous FIFO with exact occupancy and a registered head that holds
// its last value when the FIFO drains.
module ixc_probe_fifo #(
    parameter int W     = 23,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, head_idx;
    logic [LW-1:0] level_nxt;
    logic [W-1:0]  head_val;
    logic          pop_ok, push_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign pop_ok  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        level_nxt = level + LW'(push_ok) - LW'(pop_ok);
        head_idx  = pop_ok ? rd_ptr + AW'(1) : rd_ptr;
        // The new head is the incoming word when nothing older remains.
        head_val  = (push_ok && (level == LW'(pop_ok))) ? wdata : mem[head_idx];
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            rdata  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            if (level_nxt != '0) rdata <= head_val;
        end
    end
endmodule

// File: rtl/ixc_probe_capture_7.sv
// Samples a probed net, records timestamped value changes into a FIFO and
// reports records dropped while the host readback falls behind.
module ixc_probe_capture_7
    import ixc_probe_pkg::*;
#(
    parameter int WIDTH  = PROBE_WIDTH,
    parameter int DEPTH  = PROBE_DEPTH,
    parameter int TS_W   = PROBE_TS_W,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [WIDTH-1:0]      sig,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TS_W+WIDTH-1:0] out_data,
    output logic [LVL_W-1:0]      level,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    input  logic                  clr_ovf
);
    logic [TS_W-1:0]  ts;
    logic [WIDTH-1:0] prev;
    logic             armed;
    logic             push, pop, drop, full, empty;

    // First enabled sample is always the baseline record.
    assign push      = en && (!armed || (sig != prev));
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign drop      = push && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts    <= '0;
            prev  <= '0;
            armed <= 1'b0;
        end else begin
            ts    <= ts + TS_W'(1);
            armed <= en;
            if (en) prev <= sig;
        end
    end

    // Clear takes effect first so a coincident drop is still counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_ovf) begin
            overflow <= drop;
            drop_cnt <= DROP_CNT_W'(drop);
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end

    ixc_probe_fifo #(
        .W     (TS_W + WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({ts, sig}),
        .rdata (out_data),
        .level (level),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_ixc_probe_capture_7.sv
// Randomized bench for ixc_probe_capture_7 against a queue-based record model.
module tb_ixc_probe_capture_7;
    import ixc_probe_pkg::*;

    localparam int DEPTH = PROBE_DEPTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [6:0]       sig = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [REC_W-1:0] out_data;
    logic [3:0]       level;
    logic             overflow;
    logic [7:0]       drop_cnt;
    logic             clr_ovf = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    // model state
    logic [REC_W-1:0] q[$];
    logic [REC_W-1:0] m_head = '0;
    int               m_ts = 0;
    logic [6:0]       m_prev = '0;
    bit               m_armed = 1'b0;
    bit               m_ovf = 1'b0;
    int               m_cnt = 0;

    ixc_probe_capture_7 dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sig(sig),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .overflow(overflow), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_head = '0; m_ts = 0; m_prev = '0; m_armed = 1'b0; m_ovf = 1'b0; m_cnt = 0;
    endtask

    // One rising edge of the specified behaviour, from the current inputs.
    task automatic model_edge();
        probe_rec_t r;
        bit push, drop;
        push = en && (!m_armed || sig != m_prev);
        drop = 1'b0;
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (push) begin
            r.ts = m_ts[15:0];
            r.value = sig;
            if (q.size() < DEPTH) q.push_back(r);
            else drop = 1'b1;
        end
        if (clr_ovf) begin m_ovf = 1'b0; m_cnt = 0; end
        if (drop) begin m_ovf = 1'b1; if (m_cnt < 255) m_cnt++; end
        m_ts = (m_ts + 1) % 65536;
        m_armed = en;
        if (en) m_prev = sig;
        if (q.size() > 0) m_head = q[0];
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    // Asynchronous reset asserted between edges; released after a negedge.
    task automatic async_reset(input logic [6:0] rel_sig, input bit rel_en);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        chk("rst_out_data", 32'(out_data), 0);
        @(posedge clk);
        #1;
        sig = rel_sig; en = rel_en; clr_ovf = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("level", 32'(level), 32'(q.size()));
            chk("out_data", 32'(out_data), 32'(m_head));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        chk_on = 1'b1;

        // first edge sees en=0; baseline then lands at ts=1
        step();
        en = 1'b1; sig = 7'h00;
        repeat (5) step();
        chk("base_level", 32'(level), 1);
        chk("base_data", 32'(out_data), 32'h080);

        out_ready = 1'b1; sig = 7'h55;
        step();
        chk("chg55_data", 32'(out_data), 32'h355);
        sig = 7'h2A;
        step();
        chk("chg2a_data", 32'(out_data), 32'h3AA);
        chk("chg2a_valid", 32'(out_valid), 1);
        step();
        chk("empty_valid", 32'(out_valid), 0);
        chk("empty_hold", 32'(out_data), 32'h3AA);

        // fill past DEPTH with the host stalled
        async_reset(7'h01, 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sig = 7'(i + 1);
            step();
        end
        chk("full_level", 32'(level), 8);
        chk("full_ovf", 32'(overflow), 1);
        chk("full_drops", 32'(drop_cnt), 2);
        chk("full_head", 32'(out_data), 32'h001);

        out_ready = 1'b1; sig = 7'h40;
        step();
        chk("pushpop_level", 32'(level), 8);
        chk("pushpop_drops", 32'(drop_cnt), 2);
        chk("pushpop_head", 32'(out_data), 32'h082);

        out_ready = 1'b0; clr_ovf = 1'b1; sig = 7'h41;
        step();
        clr_ovf = 1'b0;
        chk("clrdrop_ovf", 32'(overflow), 1);
        chk("clrdrop_cnt", 32'(drop_cnt), 1);

        en = 1'b0; out_ready = 1'b1;
        repeat (9) step();
        chk("drained", 32'(level), 0);

        // reset mid-burst with five records queued
        en = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sig = 7'(8'h20 + i);
            step();
        end
        chk("burst_level", 32'(level), 5);
        async_reset(7'h11, 1'b1);
        step();
        chk("post_rst_base", 32'(out_data), 32'h011);
        chk("post_rst_level", 32'(level), 1);

        // drop counter saturation
        for (int i = 0; i < 300; i++) begin
            sig = 7'(i);
            step();
        end
        chk("sat_cnt", 32'(drop_cnt), 255);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("sat_clr", 32'(drop_cnt), 0);

        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 0) sig = 7'($urandom_range(0, 3) * 7'h21);
            out_ready = ($urandom_range(0, 3) != 0) && (i % 400 < 300);
            clr_ovf = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 599) == 0) async_reset(7'($urandom), 1'b1);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
